ecc_scrub_engine: RTL and testbench
===================================

Name: ecc_scrub_engine

Overview:
- Background SECDED scrubber that acts as the initiator on one port of the banked ECC memory.
- Walks every address in turn, reads the stored codeword, and checks its syndrome and overall parity.
- Writes the corrected codeword back when it finds a single-bit error. Logs and counts double-bit errors.
- Drives the memory port's en/we/addr/data pins and consumes the bank-routed read codeword; sits beside the host on that port.

Parameters:
- DATA_BITS, 12, data bits per word.
- PARITY_BITS, $clog2(DATA_BITS)+1, Hamming parity bits at power-of-two positions.
- ENCODED_WORD, DATA_BITS+PARITY_BITS, Hamming codeword length.
- CW_W, ENCODED_WORD+1, stored width: positions 1..ENCODED_WORD plus overall parity at ENCODED_WORD+1.
- MEM_WORDS, 256, addresses swept (4 banks x 64).
- ADDR_W, $clog2(MEM_WORDS), address width.
- RD_LATENCY, 1, cycles from read request to valid i_rdata (>=1).
- WR_LATENCY, 1, cycles a write occupies the port (>=1).
- CNT_W, 16, width of the error counters.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- i_start, in, 1: start a sweep; pulse, accepted only in IDLE.
- i_pause, in, 1: host wants the port; hold off new reads.
- o_busy, out, 1: sweep in progress.
- o_done, out, 1: one-cycle pulse at end of sweep.
- o_en, out, 1: memory port enable.
- o_we, out, 1: memory port write enable.
- o_addr, out, ADDR_W: memory port address.
- o_wdata, out, CW_W: corrected codeword for write-back.
- i_rdata, in, CW_W: routed read codeword.
- o_sbe_cnt, out, CNT_W: corrected-error count.
- o_dbe_cnt, out, CNT_W: uncorrectable-error count.
- o_dbe_addr, out, ADDR_W: address of the most recent double-bit error.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, address register 0. Reset in any state aborts immediately; no write is completed after reset.
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, WR_WAIT, NEXT, DONE.
- IDLE: on i_start, clear counters and o_dbe_addr, set addr=0, go to RD_REQ. i_start in any other state is ignored.
- RD_REQ:
  - If i_pause=1: stay, o_en=0.
  - Else: o_en=1, o_we=0, o_addr=addr for one cycle, go to RD_WAIT.
- RD_WAIT: o_en=0 for RD_LATENCY cycles. Capture i_rdata into a register in the cycle it is valid (request cycle + RD_LATENCY), then go to CHECK.
- CHECK (one cycle, decode of the registered word):
  - Syndrome s = XOR of indices of set bits over positions 1..ENCODED_WORD. p = XOR of all CW_W bits.
  - s=0, p=0: clean; go to NEXT.
  - p=1: single-bit error. If s=0, flip the overall parity bit; else if s<=ENCODED_WORD, flip bit s. Increment o_sbe_cnt, go to WR_REQ.
  - p=1 with s>ENCODED_WORD: treat as a double-bit error.
  - s!=0, p=0: double-bit error. Increment o_dbe_cnt, set o_dbe_addr=addr, go to NEXT.
- Counters saturate at all-ones.
- WR_REQ: o_en=1, o_we=1, o_addr=addr, o_wdata=corrected word for one cycle. i_pause does not block a write-back. Go to WR_WAIT.
- WR_WAIT: o_en=0 for WR_LATENCY cycles, then go to NEXT.
- NEXT:
  - If addr==MEM_WORDS-1, go to DONE.
  - Else addr+1 and go to RD_REQ. The address never wraps within a sweep.
- DONE: o_done=1 for one cycle, go to IDLE.
- o_busy=1 in every state except IDLE.
- o_wdata holds its last value when o_we=0.
- Clean word cost: RD_LATENCY+3 cycles per address.

Optional Feature:
- Macro: SCRUB_DBE_HALT_EN.
- Defined: a double-bit error in CHECK goes straight to DONE (early termination). o_dbe_addr holds the failing address; o_busy drops the cycle after o_done.
- Undefined: the sweep continues through all addresses, and o_dbe_addr keeps the last failing address.

Decomposition:
- Package ecc_scrub_pkg:
  - State enum scrub_state_t.
  - Status enum ecc_status_t {ECC_OK, ECC_SBE, ECC_DBE}.
  - Functions for parity-position test and codeword width.
- Sub-module secded_check: combinational; in: codeword; out: status, corrected codeword, syndrome. Instantiated once in CHECK datapath.

Test Plan:
- All 256 words clean, RD_LATENCY=1, start -> 256 reads, 0 writes, o_done at cycle 1024 after start, both counts 0.
- Bit 5 flipped at addr 0x2A -> exactly one write to 0x2A carrying the original codeword, o_sbe_cnt=1, o_dbe_cnt=0.
- Bits 3 and 9 flipped at addr 0x10 -> no write, o_dbe_cnt=1, o_dbe_addr=0x10. Without macro the sweep reaches 0xFF; with SCRUB_DBE_HALT_EN, o_done follows 0x10's CHECK and addresses 0x11+ are never read.
- Only the overall parity bit flipped at 0x00 -> SBE, write-back restores that bit, o_sbe_cnt=1.
- i_pause held 20 cycles while addr 0x2A write-back is pending -> write completes, then no o_en for the rest of the pause, resume at 0x2B, final counts unchanged.
- rst asserted during WR_WAIT -> next cycle all outputs 0 and FSM IDLE. A new i_start completes a full sweep with fresh counters.

Source files
------------

// File: rtl/ecc_scrub_engine_pkg.sv
// Shared types and helpers for the background SECDED scrubber.
// Codeword layout: Hamming position p (1..ENCODED_WORD) lives in vector
// bit p-1; the overall parity bit is the top bit (position ENCODED_WORD+1).
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        CHECK   = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        NEXT    = 3'd6,
        DONE    = 3'd7
    } scrub_state_t;

    typedef enum logic [1:0] {
        ECC_OK  = 2'd0,
        ECC_SBE = 2'd1,
        ECC_DBE = 2'd2
    } ecc_status_t;

    // True when a Hamming position holds a parity bit (power of two).
    function automatic bit is_parity_pos(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Number of Hamming parity bits protecting data_bits of payload.
    function automatic int parity_bits(input int data_bits);
        return $clog2(data_bits) + 1;
    endfunction

    // Stored codeword width: data + Hamming parity + overall parity.
    function automatic int cw_width(input int data_bits);
        return data_bits + parity_bits(data_bits) + 1;
    endfunction

endpackage

// File: rtl/ecc_scrub_engine_if.sv
// Memory-port bundle shared between the scrubber (master) and the banked
// ECC memory (slave). Names are from the scrubber's point of view.
interface ecc_scrub_engine_if #(
    parameter int ADDR_W = 8,
    parameter int CW_W   = 18
) ();
    logic              o_en;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [CW_W-1:0]   o_wdata;
    logic [CW_W-1:0]   i_rdata;

    modport master (
        output o_en,
        output o_we,
        output o_addr,
        output o_wdata,
        input  i_rdata
    );

    modport slave (
        input  o_en,
        input  o_we,
        input  o_addr,
        input  o_wdata,
        output i_rdata
    );
endinterface

// File: rtl/ecc_scrub_engine_secded_check.sv
// Combinational SECDED decode of one stored codeword: syndrome, overall
// parity, classification and the single-bit-corrected word.
module secded_check
    import ecc_scrub_pkg::*;
#(
    parameter int DATA_BITS    = 12,
    parameter int PARITY_BITS  = parity_bits(DATA_BITS),
    parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
    parameter int CW_W         = ENCODED_WORD + 1
) (
    input  logic [CW_W-1:0]        codeword,
    output ecc_status_t            status,
    output logic [CW_W-1:0]        corrected,
    output logic [PARITY_BITS-1:0] syndrome
);
    logic [PARITY_BITS-1:0] syn_s;
    logic                   par_s;
    ecc_status_t            status_s;
    logic [CW_W-1:0]        corr_s;

    assign par_s = ^codeword;

    // Syndrome: XOR of the positions of every set bit in the Hamming part.
    always_comb begin
        syn_s = {PARITY_BITS{1'b0}};
        for (int i = 1; i <= ENCODED_WORD; i++) begin
            if (codeword[i-1]) begin
                syn_s = syn_s ^ PARITY_BITS'(i);
            end else begin
                syn_s = syn_s;
            end
        end
    end

    // Classify and correct; a syndrome pointing past the word is uncorrectable.
    always_comb begin
        status_s = ECC_OK;
        corr_s   = codeword;
        if (!par_s) begin
            if (syn_s == {PARITY_BITS{1'b0}}) begin
                status_s = ECC_OK;
            end else begin
                status_s = ECC_DBE;
            end
        end else if (syn_s == {PARITY_BITS{1'b0}}) begin
            status_s         = ECC_SBE;
            corr_s[CW_W-1]   = ~codeword[CW_W-1];
        end else if (syn_s <= PARITY_BITS'(ENCODED_WORD)) begin
            status_s = ECC_SBE;
            for (int i = 1; i <= ENCODED_WORD; i++) begin
                if (PARITY_BITS'(i) == syn_s) begin
                    corr_s[i-1] = ~codeword[i-1];
                end else begin
                    corr_s[i-1] = codeword[i-1];
                end
            end
        end else begin
            status_s = ECC_DBE;
        end
    end

    assign status    = status_s;
    assign corrected = corr_s;
    assign syndrome  = syn_s;
endmodule

// File: rtl/ecc_scrub_engine.sv
// Background SECDED scrubber: sweeps every address, writes back corrected
// single-bit errors and logs/counts double-bit errors.
// Optional build macro SCRUB_DBE_HALT_EN: a double-bit error ends the sweep
// immediately instead of continuing to the last address.
// Port outputs are registered; a read enable is decided one cycle ahead from
// i_pause so the enable is high exactly in the RD_REQ cycle that issues it.
module ecc_scrub_engine
    import ecc_scrub_pkg::*;
#(
    parameter int DATA_BITS    = 12,
    parameter int PARITY_BITS  = parity_bits(DATA_BITS),
    parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
    parameter int CW_W         = ENCODED_WORD + 1,
    parameter int MEM_WORDS    = 256,
    parameter int ADDR_W       = $clog2(MEM_WORDS),
    parameter int RD_LATENCY   = 1,
    parameter int WR_LATENCY   = 1,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_pause,
    output logic                      o_busy,
    output logic                      o_done,
    ecc_scrub_engine_if.master        mem,
    output logic [CNT_W-1:0]          o_sbe_cnt,
    output logic [CNT_W-1:0]          o_dbe_cnt,
    output logic [ADDR_W-1:0]         o_dbe_addr
);
    localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int WAIT_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    scrub_state_t           state_r, next_state_s;
    logic [ADDR_W-1:0]      addr_r;
    logic [WAIT_W-1:0]      wait_cnt_r;
    logic [CW_W-1:0]        rdata_r;
    logic [CW_W-1:0]        wdata_r;
    logic                   en_r, we_r, busy_r, done_r;
    logic [CNT_W-1:0]       sbe_cnt_r, dbe_cnt_r;
    logic [ADDR_W-1:0]      dbe_addr_r;

    logic                   clr_s, capture_s, sbe_inc_s, dbe_inc_s, addr_inc_s;
    ecc_status_t            status_s;
    logic [CW_W-1:0]        corrected_s;

    secded_check #(
        .DATA_BITS    (DATA_BITS),
        .PARITY_BITS  (PARITY_BITS),
        .ENCODED_WORD (ENCODED_WORD),
        .CW_W         (CW_W)
    ) u_check (
        .codeword  (rdata_r),
        .status    (status_s),
        .corrected (corrected_s),
        .syndrome  ()
    );

    // Next-state decision and per-cycle datapath strobes.
    always_comb begin
        next_state_s = state_r;
        clr_s        = 1'b0;
        capture_s    = 1'b0;
        sbe_inc_s    = 1'b0;
        dbe_inc_s    = 1'b0;
        addr_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    clr_s        = 1'b1;
                    next_state_s = RD_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (en_r) begin
                    next_state_s = RD_WAIT;
                end else begin
                    next_state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (wait_cnt_r == WAIT_W'(RD_LATENCY - 1)) begin
                    capture_s    = 1'b1;
                    next_state_s = CHECK;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            CHECK: begin
                case (status_s)
                    ECC_OK: next_state_s = NEXT;
                    ECC_SBE: begin
                        sbe_inc_s    = 1'b1;
                        next_state_s = WR_REQ;
                    end
                    ECC_DBE: begin
                        dbe_inc_s    = 1'b1;
`ifdef SCRUB_DBE_HALT_EN
                        next_state_s = DONE;
`else
                        next_state_s = NEXT;
`endif
                    end
                    default: next_state_s = NEXT;
                endcase
            end
            WR_REQ: next_state_s = WR_WAIT;
            WR_WAIT: begin
                if (wait_cnt_r == WAIT_W'(WR_LATENCY - 1)) begin
                    next_state_s = NEXT;
                end else begin
                    next_state_s = WR_WAIT;
                end
            end
            NEXT: begin
                if (addr_r == ADDR_W'(MEM_WORDS - 1)) begin
                    next_state_s = DONE;
                end else begin
                    addr_inc_s   = 1'b1;
                    next_state_s = RD_REQ;
                end
            end
            DONE: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, wait counter and registered port/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            rdata_r    <= {CW_W{1'b0}};
            wdata_r    <= {CW_W{1'b0}};
            en_r       <= 1'b0;
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if ((state_r == RD_WAIT) || (state_r == WR_WAIT)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (clr_s) begin
                addr_r <= {ADDR_W{1'b0}};
            end else if (addr_inc_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                addr_r <= addr_r;
            end
            if (capture_s) begin
                rdata_r <= mem.i_rdata;
            end
            if (sbe_inc_s) begin
                wdata_r <= corrected_s;
            end
            en_r   <= ((next_state_s == RD_REQ) && !i_pause) || (next_state_s == WR_REQ);
            we_r   <= (next_state_s == WR_REQ);
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
        end
    end

    // Saturating error counters and last double-bit-error address.
    always_ff @(posedge clk) begin
        if (rst || clr_s) begin
            sbe_cnt_r  <= {CNT_W{1'b0}};
            dbe_cnt_r  <= {CNT_W{1'b0}};
            dbe_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (sbe_inc_s && (sbe_cnt_r != {CNT_W{1'b1}})) begin
                sbe_cnt_r <= sbe_cnt_r + CNT_W'(1);
            end
            if (dbe_inc_s) begin
                dbe_addr_r <= addr_r;
                if (dbe_cnt_r != {CNT_W{1'b1}}) begin
                    dbe_cnt_r <= dbe_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign mem.o_en    = en_r;
    assign mem.o_we    = we_r;
    assign mem.o_addr  = addr_r;
    assign mem.o_wdata = wdata_r;
    assign o_sbe_cnt   = sbe_cnt_r;
    assign o_dbe_cnt   = dbe_cnt_r;
    assign o_dbe_addr  = dbe_addr_r;
endmodule

// File: tb/tb_ecc_scrub_engine.sv
// Scoreboard bench for ecc_scrub_engine: a memory model serves reads, the
// expected port traffic of each sweep is queued from the injected faults and
// a monitor pops and compares every port event.
module tb_ecc_scrub_engine;
    import ecc_scrub_pkg::*;

    localparam int DB   = 12;
    localparam int CW   = cw_width(DB);
    localparam int EW   = CW - 1;
    localparam int MW   = 256;
    localparam int AW   = 8;
    localparam int CNTW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst, i_start, i_pause;
    logic o_busy, o_done;
    logic [CNTW-1:0] o_sbe_cnt, o_dbe_cnt;
    logic [AW-1:0]   o_dbe_addr;

    int n_tests = 0;
    int n_fail  = 0;
    ev_t exp_q[$];
    bit  pause_win = 1'b0;
    int  e_sbe, e_dbe, e_dbe_addr;

    logic [CW-1:0] mem    [MW];
    logic [CW-1:0] golden [MW];

    always #5 clk = ~clk;

    ecc_scrub_engine_if #(.ADDR_W(AW), .CW_W(CW)) mem_if ();

    ecc_scrub_engine #(
        .DATA_BITS(DB), .MEM_WORDS(MW), .RD_LATENCY(1), .WR_LATENCY(1), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause),
        .o_busy(o_busy), .o_done(o_done), .mem(mem_if.master),
        .o_sbe_cnt(o_sbe_cnt), .o_dbe_cnt(o_dbe_cnt), .o_dbe_addr(o_dbe_addr)
    );

    // Memory model: read data valid one cycle after the request.
    always @(posedge clk) begin
        if (mem_if.o_en && !mem_if.o_we) mem_if.i_rdata <= mem[mem_if.o_addr];
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Hamming encode: data in non-power-of-two positions, parity bit p covers
    // every position whose index has bit p set, overall parity on top.
    function automatic logic [CW-1:0] encode(input logic [DB-1:0] d);
        logic [CW-1:0] c;
        logic x;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= EW; pos++) begin
            if (!is_parity_pos(pos)) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int pp = 1; pp <= EW; pp = pp * 2) begin
            x = 1'b0;
            for (int q = 1; q <= EW; q++)
                if (((q & pp) != 0) && (q != pp)) x = x ^ c[q-1];
            c[pp-1] = x;
        end
        c[CW-1] = ^c[EW-1:0];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_if.o_en) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL port_event: got we=%0d addr=%0h, expected no access",
                             mem_if.o_we, mem_if.o_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.we !== mem_if.o_we) || (e.addr !== mem_if.o_addr) ||
                        (e.we && (e.data !== mem_if.o_wdata))) begin
                        n_fail++;
                        $display("FAIL port_event: got we=%0d addr=%0h data=%0h expected we=%0d addr=%0h data=%0h",
                                 mem_if.o_we, mem_if.o_addr, mem_if.o_wdata, e.we, e.addr, e.data);
                    end
                end
                if (pause_win) begin
                    n_tests++;
                    if (!mem_if.o_we) begin
                        n_fail++;
                        $display("FAIL pause_read: got read at %0h, expected none", mem_if.o_addr);
                    end
                end
            end
        end
    endtask

    task automatic init_mem();
        for (int a = 0; a < MW; a++) begin
            golden[a] = encode(DB'($urandom));
            mem[a]    = golden[a];
        end
    endtask

    task automatic flip(input int a, input int pos);
        mem[a][pos-1] = ~mem[a][pos-1];
    endtask

    // Reference: every address read in order; one flipped bit -> write of the
    // original word; two flipped bits -> logged as uncorrectable.
    task automatic build_expect();
        ev_t e;
        int  nb;
        exp_q.delete();
        e_sbe = 0; e_dbe = 0; e_dbe_addr = 0;
        for (int a = 0; a < MW; a++) begin
            e.we = 1'b0; e.addr = AW'(a); e.data = '0;
            exp_q.push_back(e);
            nb = $countones(mem[a] ^ golden[a]);
            if (nb == 1) begin
                e.we = 1'b1; e.data = golden[a];
                exp_q.push_back(e);
                e_sbe++;
            end else if (nb == 2) begin
                e_dbe++;
                e_dbe_addr = a;
`ifdef SCRUB_DBE_HALT_EN
                break;
`endif
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input bit chk_lat, input bit do_pause);
        int  n;
        bit  done_seen;
        bit  found;
        bit  wr_seen;
        build_expect();
        pulse_start();
        fork
            begin
                n = 0;
                done_seen = 1'b0;
                while (!done_seen && (n < 5000)) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (o_done) done_seen = 1'b1;
                end
            end
            begin
                if (do_pause) begin
                    found = 1'b0;
                    for (int c = 0; c < 2000 && !found; c++) begin
                        @(negedge clk);
                        if (mem_if.o_en && !mem_if.o_we && (mem_if.o_addr == 8'h2A)) found = 1'b1;
                    end
                    check({tag, "_pause_trigger"}, {31'd0, found}, 32'd1);
                    i_pause = 1'b1;
                    #1 pause_win = 1'b1;
                    wr_seen = 1'b0;
                    repeat (19) begin
                        @(negedge clk);
                        if (mem_if.o_en && mem_if.o_we && (mem_if.o_addr == 8'h2A)) wr_seen = 1'b1;
                    end
                    @(negedge clk);
                    i_pause = 1'b0;
                    pause_win = 1'b0;
                    check({tag, "_wb_during_pause"}, {31'd0, wr_seen}, 32'd1);
                end
            end
        join
        check({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
        if (chk_lat) check({tag, "_done_latency"}, n, 32'd1024);
        check({tag, "_sbe_cnt"}, {16'd0, o_sbe_cnt}, e_sbe);
        check({tag, "_dbe_cnt"}, {16'd0, o_dbe_cnt}, e_dbe);
        check({tag, "_dbe_addr"}, {24'd0, o_dbe_addr}, e_dbe_addr);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_done}, 32'd0);
        check({tag, "_en"}, {31'd0, mem_if.o_en}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_if.o_we}, 32'd0);
        check({tag, "_addr"}, {24'd0, mem_if.o_addr}, 32'd0);
        check({tag, "_wdata"}, {14'd0, mem_if.o_wdata}, 32'd0);
        check({tag, "_sbe"}, {16'd0, o_sbe_cnt}, 32'd0);
        check({tag, "_dbe"}, {16'd0, o_dbe_cnt}, 32'd0);
        check({tag, "_dbe_addr"}, {24'd0, o_dbe_addr}, 32'd0);
    endtask

    initial begin
        bit found;
        int a, p1, p2;
        bit used [MW];
        rst = 1'b1; i_start = 1'b0; i_pause = 1'b0;
        fork
            monitor_loop();
        join_none
        init_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Clean memory: reads only, fixed sweep length.
        init_mem();
        run_sweep("clean", 1'b1, 1'b0);

        // Single data-position flip at 0x2A.
        init_mem(); flip(8'h2A, 5);
        run_sweep("sbe_2a", 1'b0, 1'b0);

        // Double flip at 0x10.
        init_mem(); flip(8'h10, 3); flip(8'h10, 9);
        run_sweep("dbe_10", 1'b0, 1'b0);

        // Overall parity bit only at 0x00.
        init_mem(); flip(0, CW);
        run_sweep("par_00", 1'b0, 1'b0);

        // Host pause across the 0x2A write-back.
        init_mem(); flip(8'h2A, 5);
        run_sweep("pause", 1'b0, 1'b1);

        // Reset while the write-back at 0x05 is in its wait cycle.
        init_mem(); flip(5, 7);
        build_expect();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (mem_if.o_en && mem_if.o_we && (mem_if.o_addr == 8'h05)) found = 1'b1;
        end
        check("rst_wr_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid");
        exp_q.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_after");

        // Random faults, fresh counters after the aborted sweep.
        init_mem();
        for (int i = 0; i < MW; i++) used[i] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(MW - 1);
            while (used[a]) a = $urandom_range(MW - 1);
            used[a] = 1'b1;
            p1 = $urandom_range(CW, 1);
            flip(a, p1);
            if ($urandom_range(1) == 1) begin
                p2 = $urandom_range(CW, 1);
                while (p2 == p1) p2 = $urandom_range(CW, 1);
                flip(a, p2);
            end
        end
        run_sweep("random", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
